mci_mcu_trace_capture_ctrl: RTL and testbench
=============================================

Name: mci_mcu_trace_capture_ctrl

Overview:
- Capture controller between the MCU trace port and the MCI MCU trace buffer. It decides which retired-instruction packets get written into the buffer.
- Supports three capture modes: continuous, start-on-trigger and stop-on-trigger with a post-trigger count.
- Its qualified write enable replaces raw trace valid as the buffer's write strobe. Status outputs feed MCI debug CSRs/DMI.

Parameters:
- POST_CNT_WIDTH, 16, width of post-trigger instruction count.
- CAPTURE_CNT_WIDTH, 32, width of saturating captured-packet counter.

Ports:
- clk  input  1  clock
- rst_b  input  1  asynchronous active-low reset
- debug_en  input  1  debug unlock; 0 forces idle and blocks all writes
- cfg_arm  input  1  single-cycle pulse: latch config, clear status, start per mode
- cfg_disarm  input  1  single-cycle pulse: return to IDLE
- cfg_mode  input  2  0 continuous, 1 start-on-trigger, 2 stop-on-trigger, 3 reserved
- cfg_trig_addr  input  32  trigger PC address
- cfg_trig_on_exc  input  1  exception or interrupt also triggers
- cfg_post_count  input  POST_CNT_WIDTH  packets written after the trigger packet (stop mode)
- trace_valid  input  1  MCU trace valid
- trace_address  input  32  MCU trace PC
- trace_exception  input  1  MCU trace exception flag
- trace_interrupt  input  1  MCU trace interrupt flag
- trace_wr_en  output  1  qualified write strobe to trace buffer
- state  output  3  current FSM state encoding
- triggered  output  1  sticky: trigger seen since last arm
- frozen  output  1  sticky: stop-mode capture completed
- capture_cnt  output  CAPTURE_CNT_WIDTH  packets written since last arm, saturating

Behaviour:
- Reset: state=IDLE(0), triggered=0, frozen=0, capture_cnt=0, latched config=0. trace_wr_en=0 because it is a function of state.
- States: IDLE=0, ARMED=1, CAPTURE=2, POST=3, FROZEN=4. Other encodings are illegal and recover to IDLE.
- Latched config: mode_q, trig_addr_q, trig_exc_q, post_q are sampled only on an accepted cfg_arm. Live config changes do not affect an active capture.
- trig (combinational) = trace_valid & ((trace_address==trig_addr_q) | (trig_exc_q & (trace_exception|trace_interrupt))).
- trace_wr_en (combinational, zero latency, aligned with the trace data) = debug_en & ~cfg_disarm & trace_valid & (state==CAPTURE | state==POST | (state==ARMED & trig)).
- Priority, highest first:
  - debug_en=0: next state IDLE. Arm is ignored. Sticky status holds.
  - cfg_disarm: next state IDLE. Sticky status holds. Disarm wins over a simultaneous arm.
  - cfg_arm: accepted from any state.
    - Clears triggered, frozen and capture_cnt.
    - Next state: mode 0 or 2 -> CAPTURE, mode 1 -> ARMED, mode 3 -> IDLE.
    - The FSM transition and trigger evaluation in the arm cycle use the pre-arm state and latched config. The arm clear overrides any increment in that cycle.
- Transitions:
  - ARMED + trig -> CAPTURE, set triggered; the trigger packet is written.
  - CAPTURE (mode 0/1) holds until disarm, arm or debug_en drop.
  - CAPTURE (mode 2) + trig: trigger packet is written and triggered is set.
    - post_q==0 -> FROZEN, set frozen.
    - Otherwise -> POST, with post_cnt loaded with post_q.
  - POST: each write decrements post_cnt. A write while post_cnt==1 -> FROZEN, set frozen. Triggers in POST are ignored.
  - FROZEN: no writes; holds until arm or disarm.
- capture_cnt increments on each trace_wr_en and saturates at all-ones.
- Sticky flags and counter update on the clock after the causing cycle.
- Asynchronous reset mid-capture returns to the reset values immediately.

Test Plan:
- Mode 0: debug_en=1, arm, 10 valid packets, disarm, 3 more valid -> trace_wr_en exactly 10 pulses, capture_cnt=10, state=IDLE.
- Mode 1: trig_addr=0x1000, arm, packets 0x0F00, 0x0F04, 0x1000, 0x1004 -> no write for the first two; writes 0x1000 and 0x1004; triggered=1; capture_cnt=2.
- Mode 2: post_count=3, trig_addr=0x2000, arm, stream of 20 packets with 0x2000 at the 5th -> 5+3=8 writes, frozen=1, state=FROZEN, later packets not written.
- Mode 2 edge: post_count=0, trigger on an exception packet with cfg_trig_on_exc=1 -> trigger packet written, FROZEN next cycle, capture_cnt=5 if trigger is the 5th packet.
- Security/priority: debug_en=0 during CAPTURE with trace_valid=1 -> trace_wr_en=0 that cycle, IDLE next cycle. Arm and disarm in the same cycle -> IDLE, status unchanged.
- Re-arm from FROZEN with a new mode -> triggered=0, frozen=0, capture_cnt=0, new config latched. Reset asserted mid-POST -> all outputs return to reset values.

Source files
------------

// File: rtl/mci_mcu_trace_capture_ctrl.sv
// Trace capture controller: qualifies MCU retired-instruction packets into the
// MCI trace buffer using continuous, start-on-trigger or stop-on-trigger modes.
module mci_mcu_trace_capture_ctrl #(
    parameter int POST_CNT_WIDTH    = 16,
    parameter int CAPTURE_CNT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic                         debug_en,
    input  logic                         cfg_arm,
    input  logic                         cfg_disarm,
    input  logic [1:0]                   cfg_mode,
    input  logic [31:0]                  cfg_trig_addr,
    input  logic                         cfg_trig_on_exc,
    input  logic [POST_CNT_WIDTH-1:0]    cfg_post_count,
    input  logic                         trace_valid,
    input  logic [31:0]                  trace_address,
    input  logic                         trace_exception,
    input  logic                         trace_interrupt,
    output logic                         trace_wr_en,
    output logic [2:0]                   state,
    output logic                         triggered,
    output logic                         frozen,
    output logic [CAPTURE_CNT_WIDTH-1:0] capture_cnt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        CAPTURE = 3'd2,
        POST    = 3'd3,
        FROZEN  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_CONT  = 2'd0;
    localparam logic [1:0] MODE_START = 2'd1;
    localparam logic [1:0] MODE_STOP  = 2'd2;

    state_t                         state_q, state_d;
    logic [1:0]                     mode_q, mode_d;
    logic [31:0]                    trig_addr_q, trig_addr_d;
    logic                           trig_exc_q, trig_exc_d;
    logic [POST_CNT_WIDTH-1:0]      post_q, post_d;
    logic [POST_CNT_WIDTH-1:0]      post_cnt_q, post_cnt_d;
    logic                           triggered_q, triggered_d;
    logic                           frozen_q, frozen_d;
    logic [CAPTURE_CNT_WIDTH-1:0]   capture_cnt_q, capture_cnt_d;
    logic                           trig;
    logic                           wr_en;

    function automatic logic [CAPTURE_CNT_WIDTH-1:0] sat_inc(
        input logic [CAPTURE_CNT_WIDTH-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

    // Trigger always compares against the latched config, never the live inputs.
    assign trig = trace_valid &
                  ((trace_address == trig_addr_q) |
                   (trig_exc_q & (trace_exception | trace_interrupt)));

    assign wr_en = debug_en & ~cfg_disarm & trace_valid &
                   ((state_q == CAPTURE) | (state_q == POST) |
                    ((state_q == ARMED) & trig));

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        trig_addr_d   = trig_addr_q;
        trig_exc_d    = trig_exc_q;
        post_d        = post_q;
        post_cnt_d    = post_cnt_q;
        triggered_d   = triggered_q;
        frozen_d      = frozen_q;
        capture_cnt_d = wr_en ? sat_inc(capture_cnt_q) : capture_cnt_q;

        if (!debug_en || cfg_disarm) begin
            state_d = IDLE;
        end else if (cfg_arm) begin
            mode_d        = cfg_mode;
            trig_addr_d   = cfg_trig_addr;
            trig_exc_d    = cfg_trig_on_exc;
            post_d        = cfg_post_count;
            triggered_d   = 1'b0;
            frozen_d      = 1'b0;
            capture_cnt_d = '0;
            case (cfg_mode)
                MODE_CONT, MODE_STOP: state_d = CAPTURE;
                MODE_START:           state_d = ARMED;
                default:              state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                ARMED: begin
                    if (trig) begin
                        state_d     = CAPTURE;
                        triggered_d = 1'b1;
                    end
                end
                CAPTURE: begin
                    if ((mode_q == MODE_STOP) && trig) begin
                        triggered_d = 1'b1;
                        if (post_q == '0) begin
                            state_d  = FROZEN;
                            frozen_d = 1'b1;
                        end else begin
                            state_d    = POST;
                            post_cnt_d = post_q;
                        end
                    end
                end
                POST: begin
                    // Triggers are ignored here; only the remaining count matters.
                    if (wr_en) begin
                        post_cnt_d = post_cnt_q - 1'b1;
                        if (post_cnt_q == {{(POST_CNT_WIDTH-1){1'b0}}, 1'b1}) begin
                            state_d  = FROZEN;
                            frozen_d = 1'b1;
                        end
                    end
                end
                FROZEN:  state_d = FROZEN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q       <= IDLE;
            mode_q        <= '0;
            trig_addr_q   <= '0;
            trig_exc_q    <= 1'b0;
            post_q        <= '0;
            post_cnt_q    <= '0;
            triggered_q   <= 1'b0;
            frozen_q      <= 1'b0;
            capture_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            trig_addr_q   <= trig_addr_d;
            trig_exc_q    <= trig_exc_d;
            post_q        <= post_d;
            post_cnt_q    <= post_cnt_d;
            triggered_q   <= triggered_d;
            frozen_q      <= frozen_d;
            capture_cnt_q <= capture_cnt_d;
        end
    end

    assign trace_wr_en = wr_en;
    assign state       = state_q;
    assign triggered   = triggered_q;
    assign frozen      = frozen_q;
    assign capture_cnt = capture_cnt_q;

endmodule

// File: tb/tb_mci_mcu_trace_capture_ctrl.sv
// Directed bench: expected written addresses go into a queue, a negedge monitor
// pops and compares them whenever the DUT asserts trace_wr_en.
module tb_mci_mcu_trace_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        debug_en = 1'b1;
    logic        cfg_arm = 1'b0;
    logic        cfg_disarm = 1'b0;
    logic [1:0]  cfg_mode = 2'd0;
    logic [31:0] cfg_trig_addr = 32'h0;
    logic        cfg_trig_on_exc = 1'b0;
    logic [15:0] cfg_post_count = 16'h0;
    logic        trace_valid = 1'b0;
    logic [31:0] trace_address = 32'h0;
    logic        trace_exception = 1'b0;
    logic        trace_interrupt = 1'b0;
    logic        trace_wr_en;
    logic [2:0]  state;
    logic        triggered;
    logic        frozen;
    logic [31:0] capture_cnt;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    mci_mcu_trace_capture_ctrl #(
        .POST_CNT_WIDTH(16),
        .CAPTURE_CNT_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst_b(rst_b),
        .debug_en(debug_en),
        .cfg_arm(cfg_arm),
        .cfg_disarm(cfg_disarm),
        .cfg_mode(cfg_mode),
        .cfg_trig_addr(cfg_trig_addr),
        .cfg_trig_on_exc(cfg_trig_on_exc),
        .cfg_post_count(cfg_post_count),
        .trace_valid(trace_valid),
        .trace_address(trace_address),
        .trace_exception(trace_exception),
        .trace_interrupt(trace_interrupt),
        .trace_wr_en(trace_wr_en),
        .state(state),
        .triggered(triggered),
        .frozen(frozen),
        .capture_cnt(capture_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: every DUT write must match the oldest expected address.
    always @(negedge clk) begin
        if (trace_wr_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected: got write addr=%h, required no write", trace_address);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (trace_address !== e) begin
                    failures++;
                    $display("FAIL wr_addr: got %h, required %h", trace_address, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus, applied just after the rising edge.
    task automatic drive(input bit arm, input bit disarm, input bit valid,
                         input logic [31:0] a, input bit exc, input bit expwr);
        @(posedge clk);
        #1;
        cfg_arm         = arm;
        cfg_disarm      = disarm;
        trace_valid     = valid;
        trace_address   = a;
        trace_exception = exc;
        trace_interrupt = 1'b0;
        if (expwr) exp_q.push_back(a);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic arm(input logic [1:0] m, input logic [31:0] ta, input bit te,
                       input logic [15:0] pc);
        cfg_mode        = m;
        cfg_trig_addr   = ta;
        cfg_trig_on_exc = te;
        cfg_post_count  = pc;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic chk_drained(input string name);
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        // Reset
        #2;
        chk("rst_state", state, 0);
        chk("rst_cnt", capture_cnt, 0);
        chk("rst_flags", {triggered, frozen}, 0);
        #20 rst_b = 1'b1;
        idle();
        chk("post_rst_state", state, 0);
        chk("post_rst_wr", trace_wr_en, 0);

        // Mode 0: continuous, disarm blocks the write in its own cycle
        arm(2'd0, 32'h0, 1'b0, 16'd0);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b1, 32'h100 + 4*i, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 32'h300 + 4*i, 1'b0, 1'b0);
        idle();
        chk("m0_cnt", capture_cnt, 10);
        chk("m0_state", state, 0);
        chk_drained("m0_queue");

        // Mode 1: start on trigger address
        arm(2'd1, 32'h1000, 1'b0, 16'd0);
        idle();
        chk("m1_armed", state, 1);
        drive(1'b0, 1'b0, 1'b1, 32'h0F00, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h0F04, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h1000, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 32'h1004, 1'b0, 1'b1);
        idle();
        chk("m1_trig", triggered, 1);
        chk("m1_cnt", capture_cnt, 2);
        chk("m1_state", state, 2);
        chk_drained("m1_queue");

        // Mode 2: stop on trigger (5th packet) plus 3 post packets
        arm(2'd2, 32'h2000, 1'b0, 16'd3);
        for (int i = 0; i < 20; i++)
            drive(1'b0, 1'b0, 1'b1, (i == 4) ? 32'h2000 : 32'h3000 + 4*i, 1'b0, i < 8);
        idle();
        chk("m2_frozen", frozen, 1);
        chk("m2_trig", triggered, 1);
        chk("m2_state", state, 4);
        chk("m2_cnt", capture_cnt, 8);
        chk_drained("m2_queue");

        // Re-arm from FROZEN: post_count 0, exception trigger on 5th packet
        arm(2'd2, 32'hDEAD_0000, 1'b1, 16'd0);
        idle();
        chk("rearm_flags", {triggered, frozen}, 0);
        chk("rearm_cnt", capture_cnt, 0);
        chk("rearm_state", state, 2);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 32'h4000 + 4*i, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 32'h4010, 1'b1, 1'b1);
        idle();
        chk("exc_state", state, 4);
        chk("exc_flags", {triggered, frozen}, 2'b11);
        chk("exc_cnt", capture_cnt, 5);
        drive(1'b0, 1'b0, 1'b1, 32'h4014, 1'b0, 1'b0);
        idle();
        chk("exc_hold_cnt", capture_cnt, 5);
        chk_drained("exc_queue");

        // debug_en drop blocks writes and arm; arm+disarm resolves to IDLE
        arm(2'd0, 32'h0, 1'b0, 16'd0);
        drive(1'b0, 1'b0, 1'b1, 32'h6000, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 32'h6004, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 32'h6008, 1'b0, 1'b0);
        debug_en = 1'b0;
        #1 chk("dbg_wr_blocked", trace_wr_en, 0);
        idle();
        chk("dbg_state", state, 0);
        chk("dbg_cnt", capture_cnt, 2);
        arm(2'd0, 32'h0, 1'b0, 16'd0);
        idle();
        chk("dbg_arm_ignored", state, 0);
        debug_en = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        idle();
        chk("armdis_state", state, 0);
        chk("armdis_cnt", capture_cnt, 2);
        chk_drained("sec_queue");

        // Async reset in the middle of POST
        arm(2'd2, 32'h5000, 1'b0, 16'd5);
        drive(1'b0, 1'b0, 1'b1, 32'h5000, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 32'h5004, 1'b0, 1'b1);
        idle();
        chk("pre_rst_post", state, 3);
        #1 rst_b = 1'b0;
        trace_valid = 1'b1;
        trace_address = 32'h5008;
        #1;
        chk("mid_rst_state", state, 0);
        chk("mid_rst_flags", {triggered, frozen}, 0);
        chk("mid_rst_cnt", capture_cnt, 0);
        chk("mid_rst_wr", trace_wr_en, 0);
        #10 rst_b = 1'b1;
        idle();
        chk("after_rst_state", state, 0);
        chk_drained("rst_queue");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
